// File: rtl/qarctan_div_ctrl.sv
// Quick-arctan control stage: pops (x,y), drives an external shift-subtract divider,
// turns the signed ratio into an angle in Q(QUANT) radians and pushes it downstream.
module qarctan_div_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 32,
  parameter int QUANT      = 10,
  parameter int QUAD1      = 804,
  parameter int QUAD3      = 2412
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_empty_i,
  input  logic [DATA_WIDTH-1:0] in_x_i,
  input  logic [DATA_WIDTH-1:0] in_y_i,
  output logic                  in_rd_en_o,
  output logic                  div_start_o,
  output logic [DIV_WIDTH-1:0]  div_dividend_o,
  output logic [DIV_WIDTH-1:0]  div_divisor_o,
  input  logic                  div_done_i,
  input  logic [DIV_WIDTH-1:0]  div_quotient_i,
  input  logic                  div_overflow_i,
  input  logic                  out_full_i,
  output logic                  out_wr_en_o,
  output logic [DATA_WIDTH-1:0] out_din_o
);

  localparam int AW = DATA_WIDTH + 2;
  localparam int PW = DIV_WIDTH + 33;
  localparam logic [DATA_WIDTH:0] ONE_Y = 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_START, S_WAIT, S_MULT, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic        [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic                          neg_r_q, neg_r_d, neg_y_q, neg_y_d;
  logic signed [DATA_WIDTH-1:0]  base_q, base_d;
  logic        [DIV_WIDTH-1:0]   dividend_q, dividend_d, divisor_q, divisor_d;
  logic signed [DIV_WIDTH:0]     r_q, r_d;
  logic        [DATA_WIDTH-1:0]  out_din_q, out_din_d;

  logic        [DATA_WIDTH:0]    y_ext, abs_y;
  logic signed [AW-1:0]          x_w, ay_w, num_w, den_w;
  logic        [AW-1:0]          mag_w;
  logic signed [DIV_WIDTH:0]     quo_ext, r_w;
  logic signed [PW-1:0]          quad1_p, r_p, prod_p, base_p, angle_p, out_p;

  // abs_y is widened by one bit so y = -2^(DW-1) does not wrap.
  always_comb begin
    y_ext   = {y_q[DATA_WIDTH-1], y_q};
    abs_y   = (y_q[DATA_WIDTH-1] ? (~y_ext + ONE_Y) : y_ext) + ONE_Y;
    x_w     = {{2{x_q[DATA_WIDTH-1]}}, x_q};
    ay_w    = {1'b0, abs_y};
    num_w   = x_q[DATA_WIDTH-1] ? (x_w + ay_w) : (x_w - ay_w);
    den_w   = x_q[DATA_WIDTH-1] ? (ay_w - x_w) : (x_w + ay_w);
    mag_w   = num_w[AW-1] ? -num_w : num_w;
    quo_ext = {1'b0, div_quotient_i};
    r_w     = div_overflow_i ? '0 : (neg_r_q ? -quo_ext : quo_ext);
    quad1_p = PW'(QUAD1);
    r_p     = PW'(r_q);
    prod_p  = quad1_p * r_p;
    base_p  = PW'(base_q);
    angle_p = base_p - (prod_p >>> QUANT);
    out_p   = neg_y_q ? -angle_p : angle_p;
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    neg_r_d    = neg_r_q;
    neg_y_d    = neg_y_q;
    base_d     = base_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    r_d        = r_q;
    out_din_d  = out_din_q;
    case (state_q)
      S_IDLE: if (!in_empty_i) begin
        x_d = in_x_i;
        y_d = in_y_i;
      end
      S_PREP: begin
        neg_r_d    = num_w[AW-1];
        neg_y_d    = y_q[DATA_WIDTH-1];
        base_d     = x_q[DATA_WIDTH-1] ? DATA_WIDTH'(QUAD3) : DATA_WIDTH'(QUAD1);
        dividend_d = DIV_WIDTH'(mag_w) << QUANT;
        divisor_d  = DIV_WIDTH'(den_w);
      end
      S_WAIT: if (div_done_i) r_d = r_w;
      S_MULT: out_din_d = DATA_WIDTH'(out_p);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      neg_r_q    <= 1'b0;
      neg_y_q    <= 1'b0;
      base_q     <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      r_q        <= '0;
      out_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      neg_r_q    <= neg_r_d;
      neg_y_q    <= neg_y_d;
      base_q     <= base_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      r_q        <= r_d;
      out_din_q  <= out_din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!in_empty_i) state_d = S_PREP;
      S_PREP:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (div_done_i) state_d = S_MULT;
      S_MULT:  state_d = S_OUT;
      S_OUT:   if (!out_full_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_rd_en_o     = (state_q == S_IDLE) && !in_empty_i;
    div_start_o    = (state_q == S_START);
    out_wr_en_o    = (state_q == S_OUT) && !out_full_i;
    div_dividend_o = dividend_q;
    div_divisor_o  = divisor_q;
    out_din_o      = out_din_q;
  end

endmodule

// File: tb/tb_qarctan_div_ctrl.sv
// Directed bench for qarctan_div_ctrl with a behavioural divider and an expected-angle queue.
module tb_qarctan_div_ctrl;

  localparam int DW      = 32;
  localparam int VW      = 32;
  localparam int DIV_LAT = VW + 2;
  localparam int PIPE_LAT = 4 + DIV_LAT;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_empty;
  logic signed [DW-1:0] in_x, in_y;
  logic                 in_rd_en;
  logic                 div_start;
  logic [VW-1:0]        div_dividend, div_divisor;
  logic                 div_done;
  logic [VW-1:0]        div_quotient;
  logic                 div_overflow;
  logic                 out_full;
  logic                 out_wr_en;
  logic signed [DW-1:0] out_din;

  int checks = 0;
  int errors = 0;
  longint exp_q[$];

  // Behavioural divider: done pulses DIV_LAT cycles after the start edge.
  int            div_cnt = 0;
  logic [VW-1:0] dvd_l = '0, dvs_l = '0;
  logic          force_ovf = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_start) begin
      div_cnt <= DIV_LAT;
      dvd_l   <= div_dividend;
      dvs_l   <= div_divisor;
    end else if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
    end
  end

  assign div_done     = (div_cnt == 1);
  assign div_quotient = (dvs_l == 0) ? '1 : dvd_l / dvs_l;
  assign div_overflow = div_done && (force_ovf || dvs_l == 0);

  qarctan_div_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_empty_i     (in_empty),
    .in_x_i         (in_x),
    .in_y_i         (in_y),
    .in_rd_en_o     (in_rd_en),
    .div_start_o    (div_start),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_done_i     (div_done),
    .div_quotient_i (div_quotient),
    .div_overflow_i (div_overflow),
    .out_full_i     (out_full),
    .out_wr_en_o    (out_wr_en),
    .out_din_o      (out_din)
  );

  function automatic longint ref_angle(input longint x, input longint y, input bit ovf);
    longint ay, num, den, base, q, r, p, ang;
    ay = ((y < 0) ? -y : y) + 1;
    if (x >= 0) begin
      num = x - ay; den = x + ay; base = 804;
    end else begin
      num = x + ay; den = ay - x; base = 2412;
    end
    q   = (((num < 0) ? -num : num) * 1024) / den;
    r   = ovf ? 0 : ((num < 0) ? -q : q);
    p   = 804 * r;
    ang = base - (p >>> 10);
    return (y < 0) ? -ang : ang;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
    int n;
    n = 0;
    @(negedge clk);
    in_x = x; in_y = y; in_empty = 1'b0;
    #1;
    while (!in_rd_en && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_rd_en) check("pop_timeout", in_rd_en, 1);
    @(posedge clk); #1;
    in_empty = 1'b1;
  endtask

  task automatic receive(input string tag, input bit chk_ops, input logic [VW-1:0] e_dvd,
                         input logic [VW-1:0] e_dvs, input bit chk_lat);
    int     lat;
    longint exp;
    lat = 1;
    @(negedge clk);
    while (!out_wr_en && lat < 200) begin
      if (chk_ops && lat == 2) begin
        check({tag, "_start"}, div_start, 1);
        check({tag, "_dividend"}, div_dividend, e_dvd);
        check({tag, "_divisor"}, div_divisor, e_dvs);
      end
      if (chk_ops && lat == 3) check({tag, "_start_pulse"}, div_start, 0);
      @(negedge clk); lat++;
    end
    check({tag, "_write_seen"}, out_wr_en, 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
    check({tag, "_angle"}, out_din, exp);
    if (chk_lat) check({tag, "_latency"}, lat, PIPE_LAT);
    $display("tx %s: out_din=%0d expected=%0d latency=%0d", tag, out_din, exp, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int     bad;
    logic signed [DW-1:0] hold_val, rx, ry;

    rst_n = 1'b0; in_empty = 1'b1; in_x = '0; in_y = '0; out_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", in_rd_en, 0);
    check("rst_start", div_start, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_divisor", div_divisor, 0);
    check("rst_out_din", out_din, 0);
    rst_n = 1'b1;

    // Directed cases with known operands and angles.
    send(1000, 0);   exp_q.push_back(3);
    receive("x1000_y0", 1'b1, 32'd1022976, 32'd1001, 1'b1);
    send(0, 1000);   exp_q.push_back(1608);
    receive("x0_y1000", 1'b1, 32'd1025024, 32'd1001, 1'b1);
    send(-1000, 0);  exp_q.push_back(3214);
    receive("xm1000_y0", 1'b1, 32'd1022976, 32'd1001, 1'b1);
    send(0, -1000);  exp_q.push_back(-1608);
    receive("x0_ym1000", 1'b0, 32'd0, 32'd0, 1'b1);
    send(0, 0);      exp_q.push_back(1608);
    receive("x0_y0", 1'b1, 32'd1024, 32'd1, 1'b1);

    force_ovf = 1'b1;
    send(5, 3);      exp_q.push_back(804);
    receive("ovf_x5_y3", 1'b0, 32'd0, 32'd0, 1'b1);
    force_ovf = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rx = DW'(int'($urandom_range(1000000, 0)) - 500000);
      ry = DW'(int'($urandom_range(1000000, 0)) - 500000);
      send(rx, ry);  exp_q.push_back(ref_angle(rx, ry, 1'b0));
      receive($sformatf("rand%0d", i), 1'b0, 32'd0, 32'd0, 1'b1);
    end

    // Backpressure: output FIFO full while a result is waiting.
    out_full = 1'b1;
    send(7, -3);     exp_q.push_back(ref_angle(7, -3, 1'b0));
    repeat (PIPE_LAT + 5) @(negedge clk);
    hold_val = out_din;
    in_x = 100; in_y = 50; in_empty = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0 || out_din !== hold_val) bad++;
    end
    check("stall_clean_cycles", bad, 0);
    check("stall_value", out_din, exp_q[0]);
    out_full = 1'b0;
    #1;
    check("release_write", out_wr_en, 1);
    check("release_angle", out_din, exp_q.pop_front());
    $display("tx backpressure: out_din=%0d", out_din);
    @(negedge clk);
    check("single_write", out_wr_en, 0);
    check("idle_pop_ready", in_rd_en, 1);
    #1 in_empty = 1'b1;
    send(100, 50);   exp_q.push_back(ref_angle(100, 50, 1'b0));
    receive("after_stall", 1'b0, 32'd0, 32'd0, 1'b1);

    // Reset while the divider is busy; the stale done must be ignored.
    send(300, -200);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_rd_en", in_rd_en, 0);
    check("midrst_start", div_start, 0);
    check("midrst_wr_en", out_wr_en, 0);
    check("midrst_dividend", div_dividend, 0);
    check("midrst_divisor", div_divisor, 0);
    check("midrst_out_din", out_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_wr_en !== 1'b0 || div_start !== 1'b0) bad++;
    end
    check("stale_done_ignored", bad, 0);
    $display("tx reset_abandon: out_din=%0d", out_din);
    send(-250, 400); exp_q.push_back(ref_angle(-250, 400, 1'b0));
    receive("after_reset", 1'b0, 32'd0, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
